// File: rtl/iq_sample_packer_pkg.sv
// rtl/iq_sample_packer_pkg.sv - shared widths and defaults for the I/Q sample packer
package system_parameters;
  localparam int QUANTISATION_BITWIDTH = 8;
  localparam int SAMPLE_WIDTH          = QUANTISATION_BITWIDTH * 2;
  localparam int PACK_FACTOR_DEFAULT   = 4;
  localparam int FRAME_LEN_DEFAULT     = 64;
  localparam int PACKER_WORD_WIDTH     = SAMPLE_WIDTH * PACK_FACTOR_DEFAULT;
  localparam int DROP_CNT_WIDTH        = 16;

  typedef logic [SAMPLE_WIDTH-1:0] iq_sample_t;
endpackage

// File: rtl/iq_sample_packer_if.sv
// rtl/iq_sample_packer_if.sv - sample input and packed-word output bundle of the packer
// dropCount exists only when PACKER_DROP_CNT_EN is defined.
interface iq_sample_packer_if
  import system_parameters::*;
#(
  parameter int PACK_FACTOR = PACK_FACTOR_DEFAULT
);
  localparam int WORD_WIDTH = SAMPLE_WIDTH * PACK_FACTOR;

  iq_sample_t              quantizedData;
  logic                    inValid;
  logic                    inFrameStart;
  logic [WORD_WIDTH-1:0]   outData;
  logic                    outValid;
  logic                    outLast;
  logic                    outReady;
  logic                    overflow;
`ifdef PACKER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] dropCount;

  modport master (output quantizedData, inValid, inFrameStart, outReady,
                  input  outData, outValid, outLast, overflow, dropCount);
  modport slave  (input  quantizedData, inValid, inFrameStart, outReady,
                  output outData, outValid, outLast, overflow, dropCount);
`else
  modport master (output quantizedData, inValid, inFrameStart, outReady,
                  input  outData, outValid, outLast, overflow);
  modport slave  (input  quantizedData, inValid, inFrameStart, outReady,
                  output outData, outValid, outLast, overflow);
`endif
endinterface

// File: rtl/iq_pack_fifo.sv
// rtl/iq_pack_fifo.sv - first-word-fall-through word FIFO; head entry visible while not empty
module iq_pack_fifo
  import system_parameters::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PACKER_WORD_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/iq_sample_packer.sv
// rtl/iq_sample_packer.sv - gathers I/Q samples into frame-marked words; drops on full FIFO
// PACKER_DROP_CNT_EN adds the saturating dropCount output.
module iq_sample_packer
  import system_parameters::*;
#(
  parameter int PACK_FACTOR = PACK_FACTOR_DEFAULT,
  parameter int FRAME_LEN   = FRAME_LEN_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  iq_sample_packer_if.slave bus
);
  localparam int WORD_WIDTH = SAMPLE_WIDTH * PACK_FACTOR;
  localparam int LW         = $clog2(PACK_FACTOR);
  localparam int CW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(PACK_FACTOR - 1);
  localparam logic [CW-1:0] WORD_MAX = CW'(FRAME_LEN - 1);

  logic [PACK_FACTOR-1:0][SAMPLE_WIDTH-1:0] gather;
  logic [PACK_FACTOR-1:0][SAMPLE_WIDTH-1:0] word;
  logic [LW-1:0]         lane;
  logic [LW-1:0]         cur_lane;
  logic [CW-1:0]         word_cnt;
  logic [CW-1:0]         cur_cnt;
  logic                  complete;
  logic                  push_q;
  logic                  last_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  drop;
  logic                  overflow_q;
  logic                  full;
  logic                  empty;
  logic [WORD_WIDTH:0]   head;

  // A frame start restarts both the lane and the word position from this very sample.
  always_comb begin
    cur_lane = bus.inFrameStart ? '0 : lane;
    cur_cnt  = bus.inFrameStart ? '0 : word_cnt;
    complete = bus.inValid && (cur_lane == LANE_MAX);
    word     = gather;
    word[PACK_FACTOR-1] = bus.quantizedData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gather   <= '0;
      lane     <= '0;
      word_cnt <= '0;
      push_q   <= 1'b0;
      last_q   <= 1'b0;
      word_q   <= '0;
    end else begin
      push_q <= complete;
      if (bus.inValid) begin
        gather[cur_lane] <= bus.quantizedData;
        if (complete) begin
          lane     <= '0;
          word_cnt <= (cur_cnt == WORD_MAX) ? '0 : cur_cnt + CW'(1);
          word_q   <= word;
          last_q   <= (cur_cnt == WORD_MAX);
        end else begin
          lane     <= cur_lane + LW'(1);
          word_cnt <= cur_cnt;
        end
      end
    end
  end

  // A full FIFO is only a loss when the consumer is not taking a word this cycle.
  assign drop = push_q && full && !bus.outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

`ifdef PACKER_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
  end

  assign bus.dropCount = drop_cnt;
`else
`endif

  iq_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q && !drop),
    .push_data ({last_q, word_q}),
    .pop       (bus.outReady),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign bus.outData  = head[WORD_WIDTH-1:0];
  assign bus.outLast  = head[WORD_WIDTH];
  assign bus.outValid = !empty;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_iq_sample_packer.sv
// tb/tb_iq_sample_packer.sv - directed bench for iq_sample_packer (PACK_FACTOR=4, FRAME_LEN=4, FIFO_DEPTH=4)
module tb_iq_sample_packer;
  import system_parameters::*;

  localparam int PF = 4;
  localparam int FL = 4;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  iq_sample_packer_if #(.PACK_FACTOR(PF)) bus ();

  iq_sample_packer #(
    .PACK_FACTOR (PF),
    .FRAME_LEN   (FL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] samp(input logic [7:0] b);
    return {~b, b};
  endfunction

  function automatic logic [63:0] wexp(input logic [7:0] b);
    return {samp(b + 8'd3), samp(b + 8'd2), samp(b + 8'd1), samp(b)};
  endfunction

  task automatic send(input logic [15:0] d, input logic fs);
    bus.quantizedData = d;
    bus.inValid       = 1'b1;
    bus.inFrameStart  = fs;
    @(posedge clk);
    #1;
    bus.inValid       = 1'b0;
    bus.inFrameStart  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Streams n words with outReady=1; pos is the frame position of the first word.
  task automatic send_words(input int n, input logic fs, input int pos, input logic [7:0] base);
    int j;
    for (int i = 0; i < 4 * n; i++) begin
      send(samp(base + 8'(i)), fs && (i == 0));
      if (i >= 4 && (i % 4) == 0) begin
        j = i / 4 - 1;
        chk("stream_valid", 64'(bus.outValid), 64'd1);
        chk("stream_data", bus.outData, wexp(base + 8'(4 * j)));
        chk("stream_last", 64'(bus.outLast), 64'(((pos + j) % 4) == 3));
      end
    end
    chk("tail_latency", 64'(bus.outValid), 64'd0);
    idle(1);
    j = n - 1;
    chk("tail_valid", 64'(bus.outValid), 64'd1);
    chk("tail_data", bus.outData, wexp(base + 8'(4 * j)));
    chk("tail_last", 64'(bus.outLast), 64'(((pos + j) % 4) == 3));
    idle(1);
    chk("drained", 64'(bus.outValid), 64'd0);
  endtask

  initial begin
    bus.quantizedData = '0;
    bus.inValid       = 1'b0;
    bus.inFrameStart  = 1'b0;
    bus.outReady      = 1'b1;
    idle(2);
    chk("rst_data", bus.outData, 64'd0);
    chk("rst_valid", 64'(bus.outValid), 64'd0);
    chk("rst_last", 64'(bus.outLast), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("rst_dropcount", 64'(bus.dropCount), 64'd0);
`endif
    rst = 1'b1;
    idle(1);

    // First word: latency and lane ordering
    send(16'h0101, 1'b0);
    send(16'h0202, 1'b0);
    send(16'h0303, 1'b0);
    send(16'h0404, 1'b0);
    chk("first_latency", 64'(bus.outValid), 64'd0);
    idle(1);
    chk("first_valid", 64'(bus.outValid), 64'd1);
    chk("first_data", bus.outData, 64'h0404_0303_0202_0101);
    chk("first_last", 64'(bus.outLast), 64'd0);
    idle(1);
    chk("first_drained", 64'(bus.outValid), 64'd0);

    // Full frame plus one word; last only on the fourth
    send_words(5, 1'b1, 0, 8'h10);

    // Back-pressure: fifth word dropped
    bus.outReady = 1'b0;
    for (int i = 0; i < 20; i++) send(samp(8'h30 + 8'(i)), i == 0);
    chk("ovf_before_drop", 64'(bus.overflow), 64'd0);
    idle(1);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
`ifdef PACKER_DROP_CNT_EN
    chk("dropcount_one", 64'(bus.dropCount), 64'd1);
`endif
    chk("bp_valid", 64'(bus.outValid), 64'd1);
    chk("bp_head", bus.outData, wexp(8'h30));
    idle(2);
    chk("bp_hold_data", bus.outData, wexp(8'h30));
    chk("bp_hold_last", 64'(bus.outLast), 64'd0);
    bus.outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_data", bus.outData, wexp(8'h30 + 8'(4 * k)));
      chk("bp_last", 64'(bus.outLast), 64'(k == 3));
      idle(1);
    end
    chk("bp_drained", 64'(bus.outValid), 64'd0);

    // Mid-word frame start discards the partial word
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'hAAAA, 1'b1);
    send(16'hBBBB, 1'b0);
    send(16'hCCCC, 1'b0);
    send(16'hDDDD, 1'b0);
    idle(1);
    chk("fs_valid", 64'(bus.outValid), 64'd1);
    chk("fs_data", bus.outData, 64'hDDDD_CCCC_BBBB_AAAA);
    chk("fs_last", 64'(bus.outLast), 64'd0);
    idle(1);
    chk("fs_drained", 64'(bus.outValid), 64'd0);
    send_words(3, 1'b0, 1, 8'h50);

    // Reset mid-word and mid-frame with two words queued
    bus.outReady = 1'b0;
    for (int i = 0; i < 10; i++) send(samp(8'h60 + 8'(i)), i == 0);
    chk("pre_rst_valid", 64'(bus.outValid), 64'd1);
    chk("pre_rst_overflow_sticky", 64'(bus.overflow), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data", bus.outData, 64'd0);
    chk("mid_rst_valid", 64'(bus.outValid), 64'd0);
    chk("mid_rst_last", 64'(bus.outLast), 64'd0);
    chk("mid_rst_overflow", 64'(bus.overflow), 64'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("mid_rst_dropcount", 64'(bus.dropCount), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.outReady = 1'b1;
    send_words(4, 1'b0, 0, 8'h70);

    // Push into a full FIFO while the consumer pops: no drop
    bus.outReady = 1'b0;
    for (int i = 0; i < 20; i++) send(samp(8'h90 + 8'(i)), i == 0);
    chk("full_valid", 64'(bus.outValid), 64'd1);
    chk("full_head", bus.outData, wexp(8'h90));
    bus.outReady = 1'b1;
    idle(1);
    chk("full_no_overflow", 64'(bus.overflow), 64'd0);
`ifdef PACKER_DROP_CNT_EN
    chk("full_no_drop", 64'(bus.dropCount), 64'd0);
`endif
    for (int k = 1; k < 5; k++) begin
      chk("full_data", bus.outData, wexp(8'h90 + 8'(4 * k)));
      chk("full_last", 64'(bus.outLast), 64'(k == 3));
      idle(1);
    end
    chk("full_drained", 64'(bus.outValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iq_sample_packer.md
# iq_sample_packer

Downstream neighbour of the quantizer. Collects quantized I/Q samples, one per `inValid`, into wide words of `PACK_FACTOR` samples. Buffers completed words in a small FIFO and presents them on a valid/ready output with frame-end marking, for the fronthaul/DMA stage. The quantizer cannot be back-pressured, so overflow is detected, counted and flagged rather than stalled.

## Interface
- `PACK_FACTOR`, 4: samples per output word; power of two, ≥2.
- `FRAME_LEN`, 64: output words per frame; `outLast` on the final word.
- `FIFO_DEPTH`, 4: output FIFO depth in words; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `quantizedData` in `QUANTISATION_BITWIDTH*2`: sample; Q in upper half, I in lower half.
- `inValid` in 1: sample present this cycle.
- `inFrameStart` in 1: qualified by `inValid`; this sample starts a new frame.
- `outData` out `QUANTISATION_BITWIDTH*2*PACK_FACTOR`: packed word.
- `outValid` out 1: word available.
- `outLast` out 1: word is the last of its frame.
- `outReady` in 1: consumer accepts word.
- `overflow` out 1: sticky; a completed word was dropped.
- `dropCount` out 16: dropped-word count; present only with macro (see Configuration).

## Operation
- Lane counter 0..`PACK_FACTOR`-1 selects the gather slot. Sample k occupies bits `[k*2QW +: 2QW]`, where QW = `QUANTISATION_BITWIDTH`; sample 0 is in the LSBs.
- Each `inValid` writes the current slot and advances the lane. When lane `PACK_FACTOR`-1 is written, the assembled word is pushed to the FIFO and the lane wraps to 0.
- Word counter 0..`FRAME_LEN`-1 advances on every completed word, whether pushed or dropped, so frame alignment survives overflow. Push carries last = (count == `FRAME_LEN`-1). The counter wraps to 0 after the last word.
- `inFrameStart` with `inValid`:
  - Any partial word in the gather register is discarded and never emitted.
  - The sample goes to lane 0.
  - The word counter resets to 0.
  - Ignored when `inValid`=0.
- FIFO full at push, with no pop in the same cycle:
  - The word is dropped.
  - `overflow` is set and stays set until reset.
  - `dropCount` increments, saturating at 0xFFFF.
- Push and pop in the same cycle while full: the push is accepted and no drop occurs.
- Output:
  - `outValid` = FIFO not empty.
  - A transfer occurs on `outValid && outReady`.
  - `outData` and `outLast` are held stable while `outValid && !outReady`.
  - `outReady` with `outValid`=0 has no effect.
- Reset, including mid-frame or mid-word: all outputs go to 0, the FIFO empties, the lane counter and word counter return to 0, and the partial word is lost.

## Timing
- Reset values: `outData`=0, `outValid`=0, `outLast`=0, `overflow`=0, `dropCount`=0.
- Latency: sample completing a word on edge N → `outValid`=1 with that word after edge N+1. The FIFO is first-word-fall-through with registered outputs.
- `overflow` rises on the edge after the dropping push.
- Sustained throughput: one sample per cycle in, one word per `PACK_FACTOR` cycles out. With `outReady`=1, the FIFO never exceeds one entry.
- Back-pressure tolerance: `outReady` held low for `FIFO_DEPTH*PACK_FACTOR` input cycles causes no drop when starting from an empty FIFO.

## Configuration
- `PACKER_DROP_CNT_EN` defined:
  - `dropCount` port and its 16-bit saturating counter are present.
- Undefined:
  - Port and counter are absent.
  - `overflow` is still implemented and behaves identically.

## Structure
- Package `system_parameters` gains:
  - `PACKER_WORD_WIDTH` = `QUANTISATION_BITWIDTH*2*PACK_FACTOR_DEFAULT`.
  - `PACK_FACTOR_DEFAULT`, `FRAME_LEN_DEFAULT`.
  - `DROP_CNT_WIDTH` = 16.
- Existing `QUANTISATION_BITWIDTH` is reused from the package.
- One sub-module, `iq_pack_fifo`:
  - Synchronous first-word-fall-through FIFO of depth `FIFO_DEPTH`, with width `PACKER_WORD_WIDTH+1` (data + last).
  - Exposes full/empty.
  - Asynchronous active-low `rst`.
- Gather register, lane counter, word counter and drop logic stay in the top module.

## Test plan
(QW=8, `PACK_FACTOR`=4, `FRAME_LEN`=4, `FIFO_DEPTH`=4)
- Samples 0x0101, 0x0202, 0x0303, 0x0404 on consecutive cycles, `outReady`=1 → one word 0x0404_0303_0202_0101, `outValid` one cycle after the fourth sample, `outLast`=0.
- 16 consecutive samples, `outReady`=1 → four words; `outLast`=1 on the fourth word only; the 17th–20th samples' word has `outLast`=0.
- `outReady`=0 for 20 samples (5 words) → first four words kept, fifth dropped, `overflow`=1, `dropCount`=1. The released words arrive in order with the last flag on word 4.
- Two samples, then `inFrameStart` with 0xAAAA plus three more samples → the first two samples are never emitted; the word's LSB lane is 0xAAAA; the word counter restarts.
- FIFO full with `outReady`=1 on the same cycle as a push → no drop, `overflow` stays 0.
- `rst` low mid-word and mid-frame with the FIFO holding 2 words → all outputs 0 immediately; after release, the next 4 samples form a fresh word with `outLast` after 4 words.
